// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {IDLE, FILL} state_t;

  // Field widths for the default geometry (32-bit address, 4-word lines, 64 lines).
  localparam int OFFSET_BITS = 2;
  localparam int INDEX_BITS  = 6;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2;

  // Field widths for an arbitrary geometry.
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int addr_width, input int line_words, input int num_lines);
    return addr_width - $clog2(num_lines) - $clog2(line_words) - 2;
  endfunction

  // Extract a bit field from a byte address. The address is zero-extended to
  // 64 bits by the caller, and the result is narrowed by the caller.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                             input int width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  // Word offset within a line. Bits [1:0] select a byte and are ignored.
  function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int line_words);
    return addr_field(addr, 2, $clog2(line_words));
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int line_words,
                                             input int num_lines);
    return addr_field(addr, 2 + $clog2(line_words), $clog2(num_lines));
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int addr_width,
                                           input int line_words, input int num_lines);
    return addr_field(addr, 2 + $clog2(line_words) + $clog2(num_lines),
                      tag_bits(addr_width, line_words, num_lines));
  endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Refill controller: IDLE/FILL state machine, word counter, latched line
// address and stale flag. Drives the memory bus and the array write strobes.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  localparam int OB     = offset_bits(LINE_WORDS),
  localparam int IB     = index_bits(NUM_LINES),
  localparam int TB     = tag_bits(ADDR_WIDTH, LINE_WORDS, NUM_LINES),
  localparam int BASE_W = TB + IB
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cache_rd,
  input  logic                  hit,
  input  logic [BASE_W-1:0]     req_base,
  input  logic                  invalidate,
  input  logic                  mem_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  data_we,
  output logic                  tag_we,
  output logic                  valid_set,
  output logic [IB-1:0]         fill_index,
  output logic [TB-1:0]         fill_tag,
  output logic [OB-1:0]         fill_word
);

  localparam logic [OB-1:0] LAST_WORD = OB'(LINE_WORDS - 1);

  state_t            state_q, state_d;
  logic [OB-1:0]     cnt_q, cnt_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              stale_q, stale_d;

  // State register; reset abandons any fill in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      stale_q <= stale_d;
    end
  end

  // Next-state and write-strobe decode. Words are fetched in order; a fill
  // always runs to completion regardless of what fetch is asking for now.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    stale_d   = stale_q;
    data_we   = 1'b0;
    tag_we    = 1'b0;
    valid_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (cache_rd && !hit) begin
          state_d = FILL;
          base_d  = req_base;
          cnt_d   = '0;
          stale_d = 1'b0;
        end
      end
      FILL: begin
        if (invalidate) stale_d = 1'b1;
        if (!mem_waitrequest) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            tag_we = 1'b1;
            // An invalidate on the final beat also keeps the line invalid.
            valid_set = ~stale_q & ~invalidate;
            state_d   = IDLE;
            stale_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode registered state only, so they are glitch-free.
  assign mem_rd     = (state_q == FILL);
  assign mem_addr   = mem_rd ? {base_q, cnt_q, 2'b00} : '0;
  assign fill_index = base_q[IB-1:0];
  assign fill_tag   = base_q[BASE_W-1:IB];
  assign fill_word  = cnt_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with zero-latency hits, in-order
// line refill and single-cycle global invalidate.
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic                  cache_rd,
  output logic [DATA_WIDTH-1:0] cache_data,
  output logic                  cache_waitrequest,
  input  logic                  invalidate,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_waitrequest
);

  localparam int OB = offset_bits(LINE_WORDS);
  localparam int IB = index_bits(NUM_LINES);
  localparam int TB = tag_bits(ADDR_WIDTH, LINE_WORDS, NUM_LINES);

  logic [OB-1:0] req_offset;
  logic [IB-1:0] req_index;
  logic [TB-1:0] req_tag;

  logic [DATA_WIDTH-1:0] data_ram [NUM_LINES*LINE_WORDS];
  logic [TB-1:0]         tag_ram  [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_q;

  logic          hit;
  logic          data_we, tag_we, valid_set;
  logic [IB-1:0] fill_index;
  logic [TB-1:0] fill_tag;
  logic [OB-1:0] fill_word;

  assign req_offset = OB'(addr_offset(64'(cache_addr), LINE_WORDS));
  assign req_index  = IB'(addr_index(64'(cache_addr), LINE_WORDS, NUM_LINES));
  assign req_tag    = TB'(addr_tag(64'(cache_addr), ADDR_WIDTH, LINE_WORDS, NUM_LINES));

  // No hits while a fill is running (mem_rd is the FILL state decode), even
  // for addresses already resident.
  assign hit = valid_q[req_index] & (tag_ram[req_index] == req_tag) & ~mem_rd;

  assign cache_waitrequest = cache_rd & ~hit;
  assign cache_data        = hit ? data_ram[{req_index, req_offset}] : '0;

  // Refill data write; the data array is never reset.
  always_ff @(posedge clock) begin
    if (data_we) data_ram[{fill_index, fill_word}] <= mem_data;
  end

  // Tag write on the last beat of a fill; the tag array is never reset.
  always_ff @(posedge clock) begin
    if (tag_we) tag_ram[fill_index] <= fill_tag;
  end

  // Valid bits: global clear wins over a fill completing in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (invalidate) begin
      valid_q <= '0;
    end else if (valid_set) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  icache_fill_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES)
  ) u_fill_ctrl (
    .clock           (clock),
    .reset_n         (reset_n),
    .cache_rd        (cache_rd),
    .hit             (hit),
    .req_base        ({req_tag, req_index}),
    .invalidate      (invalidate),
    .mem_waitrequest (mem_waitrequest),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .data_we         (data_we),
    .tag_we          (tag_we),
    .valid_set       (valid_set),
    .fill_index      (fill_index),
    .fill_tag        (fill_tag),
    .fill_word       (fill_word)
  );

endmodule
